alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multicycle ALU for the MIPS multicycle datapath, the successor to the 8-op combinational ALU. Single-cycle ops complete in one clock; 32-bit multiply runs iteratively. A `start`/`busy`/`done` handshake lets the control FSM stall on long ops. Result and flags are registered and held, so the datapath can read ALUOut directly without an extra capture register.

## Interface
- `WIDTH`, 32, operand/result width; ≥ 4, power of two.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; not overridden).

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: operation request; sampled only when `busy` = 0.
- `select` in 4: opcode; sampled with `start`.
- `a` in WIDTH: operand A; sampled with `start`.
- `b` in WIDTH: operand B; sampled with `start`.
- `shamt` in SHW: shift amount; sampled with `start`.
- `busy` out 1: multiply in progress.
- `done` out 1: one-cycle pulse; `y` and flags valid from this cycle on.
- `y` out WIDTH: registered result; held until the next completion.
- `zero` out 1: `y` == 0, combinational from the `y` register.
- `carry` out 1: registered carry flag.
- `overflow` out 1: registered signed-overflow flag.

## Operation
- **Opcodes**
  - 0000 ADD: a+b.
  - 0001 AND.
  - 0010 OR.
  - 0011 XOR.
  - 0100 NOT a.
  - 0101 SLL a by `shamt`.
  - 0110 SRL.
  - 0111 SRA.
  - 1000 SUB: a−b.
  - 1001 SLT (signed): y = {0…,1} if a<b.
  - 1010 SLTU (unsigned).
  - 1011 MUL: low WIDTH bits of a×b, unsigned.
  - 1100–1111 reserved: y = 0, flags 0, completes as a single-cycle op.
- **Flags**
  - ADD: carry = carry-out of a+b.
  - SUB: carry = carry-out of a+~b+1 (1 means a ≥ b unsigned).
  - ADD/SUB: overflow = standard two's-complement overflow.
  - All other ops: carry = 0 and overflow = 0.
- **Arithmetic**
  - All arithmetic is modulo 2^WIDTH.
  - Shifts use a barrel shifter. `shamt` = 0 passes `a` through.
  - SRA replicates a[WIDTH-1].
- **FSM**
  - States: IDLE, MUL.
  - IDLE → MUL on `start` with `select` = MUL.
  - MUL → IDLE when the step counter reaches WIDTH.
  - All other `start`s stay in IDLE.
- **Multiply**
  - Shift-add: the multiplicand shifts left and the multiplier shifts right.
  - One step per clock. The accumulator adds the multiplicand when the multiplier LSB = 1.
- **Start rules**
  - `start` while `busy` = 1 is ignored; no queuing.
  - `start` in the cycle `done` is high is accepted.
- **Reset**
  - Values: state IDLE, `busy` 0, `done` 0, `y` 0, `zero` 1, `carry` 0, `overflow` 0, counter 0.
  - A reset during MUL aborts the multiply with no `done` pulse.

## Timing
- **Single-cycle ops:** `start` sampled at edge k. `y`, flags and `done` = 1 are updated at edge k, so they are visible in the cycle after k. `done` drops at edge k+1 unless another op completes at that edge.
- **MUL:**
  - `start` at edge k loads the operands, clears the accumulator and sets `busy`.
  - Steps execute at edges k+1 … k+WIDTH.
  - At edge k+WIDTH: `y` = product, `carry`/`overflow` = 0, `done` = 1, `busy` = 0.
  - Total latency is WIDTH clocks after the start edge.
- **Input stability:** `a`, `b`, `select` and `shamt` may change freely after the start edge; internal copies are used.
- **Output hold:** `y` and flags change only on completion or reset.
- **Back-to-back single-cycle ops:** `start` held high issues one op per clock, and `done` stays high continuously.

## Structure
- **Package `alu_mc_pkg`:**
  - localparam opcodes: OP_ADD … OP_MUL.
  - FSM state encoding: ST_IDLE, ST_MUL.
- **Sub-module `alu_mul_iter`:**
  - Contains the shift-add datapath and step counter.
  - Parameter: WIDTH.
  - Ports: `load`, `a`, `b`, `step`, `product`, `last`.
- **Top level:** holds the FSM, the combinational single-cycle op mux, and the output registers.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → `y` = 0, `zero` = 1, `busy` = 0, `done` = 0 immediately, without waiting for a clock edge.
- **ADD overflow:** ADD a = 32'h7FFFFFFF, b = 1 → one clock later `y` = 32'h80000000, `overflow` = 1, `carry` = 0, `done` pulse of one cycle.
- **SUB equal:** SUB a = 5, b = 5 → `y` = 0, `zero` = 1, `carry` = 1, `overflow` = 0. Then SLT a = 32'hFFFFFFFF, b = 1 → `y` = 1. Then SLTU on the same operands → `y` = 0.
- **Shifts:** SRA a = 32'h80000000, `shamt` = 4 → `y` = 32'hF8000000. SLL a = 1, `shamt` = 31 → `y` = 32'h80000000.
- **MUL:** MUL a = 32'h0001_0003, b = 32'h0000_0005 → `busy` high for 32 clocks, `y` = 32'h0005_000F with `done` at edge k+32. A `start` issued during `busy` is ignored and `y` is unchanged.
- **Abort and back-to-back:** assert `reset` at step 10 of a MUL → no `done`, back in IDLE. Then hold `start` with ADD on three consecutive cycles → three results on consecutive cycles, `done` high for three cycles.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared opcodes and FSM state encoding for the multicycle ALU.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: low WIDTH bits of a*b, one step per clock.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Accumulator value after the current step, so the final step's result
  // can be captured by the caller on the same edge.
  assign product = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last    = step && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle op mux plus iterative multiply behind a
// start/busy/done handshake; result and flags are registered and held.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] op_y;
  logic             op_c, op_v;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .a       (a),
    .b       (b),
    .step    (mul_step),
    .product (mul_product),
    .last    (mul_last)
  );

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    op_y = '0;
    op_c = 1'b0;
    op_v = 1'b0;
    case (select)
      OP_ADD: begin
        op_y = sum[WIDTH-1:0];
        op_c = sum[WIDTH];
        op_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        op_y = diff[WIDTH-1:0];
        op_c = diff[WIDTH];
        op_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  op_y = a & b;
      OP_OR:   op_y = a | b;
      OP_XOR:  op_y = a ^ b;
      OP_NOT:  op_y = ~a;
      OP_SLL:  op_y = a << shamt;
      OP_SRL:  op_y = a >> shamt;
      OP_SRA:  op_y = $unsigned($signed(a) >>> shamt);
      OP_SLT:  op_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: op_y = {{(WIDTH-1){1'b0}}, (a < b)};
      default: op_y = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (select == OP_MUL) begin
            state_d  = ST_MUL;
            mul_load = 1'b1;
          end else begin
            y_d     = op_y;
            carry_d = op_c;
            ovf_d   = op_v;
            done_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          y_d     = mul_product;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == ST_MUL);
  assign done     = done_q;
  assign y        = y_q;
  assign zero     = (y_q == '0);
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  select;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, zero, carry, overflow;
  logic [31:0] y;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_y = '0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .select(select),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
    .y(y), .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Returns {carry, overflow, result}.
  function automatic logic [33:0] model(input logic [3:0] s, input logic [31:0] x,
                                        input logic [31:0] z, input logic [4:0] sh);
    longint sx, sz, r, lim;
    logic [63:0] u;
    logic c, v;
    logic [31:0] res;
    sx = longint'($signed(x));
    sz = longint'($signed(z));
    lim = 64'sd2147483647;
    c = 1'b0; v = 1'b0; res = '0; r = 0; u = '0;
    case (s)
      4'd0: begin
        u = {32'b0, x} + {32'b0, z};
        res = u[31:0]; c = u[32];
        r = sx + sz; v = (r > lim) || (r < -lim - 1);
      end
      4'd1: res = x & z;
      4'd2: res = x | z;
      4'd3: res = x ^ z;
      4'd4: res = ~x;
      4'd5: res = x << sh;
      4'd6: res = x >> sh;
      4'd7: begin r = sx >>> sh; res = r[31:0]; end
      4'd8: begin
        res = x - z; c = (x >= z);
        r = sx - sz; v = (r > lim) || (r < -lim - 1);
      end
      4'd9:  res = (sx < sz) ? 32'd1 : 32'd0;
      4'd10: res = (x < z) ? 32'd1 : 32'd0;
      4'd11: begin u = {32'b0, x} * {32'b0, z}; res = u[31:0]; end
      default: res = '0;
    endcase
    return {c, v, res};
  endfunction

  // Called at posedge+1; issues one op and checks its completion.
  task automatic do_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] z,
                       input logic [4:0] sh, input bit poke_busy);
    logic [33:0] m;
    int n;
    m = model(s, x, z, sh);
    start = 1'b1; select = s; a = x; b = z; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom); select = 4'($urandom);
    if (s == OP_MUL) begin
      chk("mul_busy_set", busy, 1'b1);
      n = 0;
      do begin
        if (poke_busy && n == 5) begin
          start = 1'b1; select = OP_ADD; a = 32'd1; b = 32'd1;
        end
        @(posedge clk); #1;
        n++;
        if (poke_busy && n == 6) begin
          start = 1'b0;
          chk("ignored_start_busy", busy, 1'b1);
          chk("ignored_start_y", y, last_y);
        end
      end while (!done && n < 40);
      chk("mul_latency", n, 32);
      chk("mul_busy_clr", busy, 1'b0);
    end
    chk("done", done, 1'b1);
    chk("y", y, m[31:0]);
    chk("carry", carry, m[33]);
    chk("overflow", overflow, m[32]);
    chk("zero", zero, (m[31:0] == 32'd0));
    last_y = m[31:0];
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    chk("y_hold", y, last_y);
  endtask

  initial begin
    logic [33:0] m;
    logic [31:0] bx [3];
    logic [31:0] bz [3];
    int dcnt;
    reset = 1'b1; start = 1'b0; select = '0; a = '0; b = '0; shamt = '0;
    #2;
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op(OP_ADD,  32'h7FFFFFFF, 32'd1, 5'd0, 1'b0);
    do_op(OP_SUB,  32'd5, 32'd5, 5'd0, 1'b0);
    do_op(OP_SLT,  32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
    do_op(OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
    do_op(OP_SRA,  32'h80000000, 32'd0, 5'd4, 1'b0);
    do_op(OP_SLL,  32'd1, 32'd0, 5'd31, 1'b0);
    do_op(OP_SRL,  32'h80000000, 32'd0, 5'd0, 1'b0);
    do_op(4'hE,    32'h12345678, 32'h1, 5'd3, 1'b0);
    do_op(OP_MUL,  32'h0001_0003, 32'h0000_0005, 5'd0, 1'b1);

    // Abort a multiply mid-flight with an asynchronous reset.
    start = 1'b1; select = OP_MUL; a = 32'hDEAD_BEEF; b = 32'h0000_0077;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_y", y, 0);
    chk("abort_zero", zero, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    last_y = '0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // Back-to-back single-cycle ops with start held high.
    for (int i = 0; i < 3; i++) begin
      bx[i] = $urandom; bz[i] = $urandom;
    end
    start = 1'b1; select = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      a = bx[i]; b = bz[i];
      @(posedge clk); #1;
      m = model(OP_ADD, bx[i], bz[i], 5'd0);
      chk("b2b_done", done, 1);
      chk("b2b_y", y, m[31:0]);
      chk("b2b_carry", carry, m[33]);
      last_y = m[31:0];
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done_drop", done, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] rx, rz;
      rx = $urandom; rz = $urandom;
      if (i % 4 == 0) rz = rx;
      do_op(4'($urandom_range(0, 15)), rx, rz, 5'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
